interp_tap_feeder: RTL and testbench
====================================

Name: interp_tap_feeder

Overview:
Producer side of the interpolation filter datapath. Accepts input samples over a valid/ready handshake and upsamples each by INTERP, by zero-stuffing or sample-and-hold. Each upsampled sample is shifted into a NUM_TAPS-deep signed delay line. The full tap vector is presented with valid/ready to the coefficient multiply and add_sat_tree stage.

Parameters:
DATA_WIDTH, 6, signed sample width; taps carry the same width.
NUM_TAPS, 4, delay line depth; >= 1.
INTERP, 2, upsampling factor L; >= 1.
ZERO_STUFF, 1, 1 = insert zeros for phases 1..L-1; 0 = repeat the last accepted sample.

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
in_valid  input  1  input sample valid
in_ready  output  1  block accepts in_data this cycle
in_data  input  signed DATA_WIDTH  input sample
taps_valid  output  1  taps_out holds a new upsampled tap vector
out_ready  input  1  downstream consumes taps_out this cycle
taps_out  output  signed [DATA_WIDTH-1:0] x [NUM_TAPS-1:0] (unpacked)  delay line; index 0 = newest

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high. Reset takes effect immediately, independent of clk.
- Reset values:
  - taps_out all 0
  - taps_valid 0
  - phase counter 0
  - hold register 0
  - in_ready 1 once reset is released (combinational, see below)
- Advance condition: adv = !taps_valid || out_ready.
- State is defined by the phase counter, range 0..INTERP-1:
  - IDLE (phase == 0): in_ready = adv.
    - If in_valid && in_ready: shift in_data into taps_out[0]; taps_out[i] <= taps_out[i-1]; hold <= in_data; taps_valid <= 1; phase <= (INTERP > 1) ? 1 : 0.
    - Else if adv: taps_valid <= 0; taps unchanged.
  - EMIT (phase 1..INTERP-1): in_ready = 0.
    - If adv: shift in (ZERO_STUFF ? 0 : hold); taps_valid <= 1; phase <= (phase == INTERP-1) ? 0 : phase + 1.
    - If !adv: taps, phase and taps_valid all hold.
- Latency: an accepted sample appears in taps_out[0] with taps_valid = 1 on the next cycle.
- Throughput: one input per INTERP cycles at full out_ready. With INTERP = 1 there is no EMIT state: one input per cycle, pure delay line.
- Input underrun: output phases never stall waiting for input. Once in IDLE, taps_valid drops only if the downstream consumed the last vector and no input has arrived.
- Backpressure: while taps_valid && !out_ready, every register holds and in_ready = 0. No sample or phase is dropped or duplicated.
- Arithmetic: no scaling and no saturation. Values pass bit-exact, including -2^(DATA_WIDTH-1). Gain compensation belongs to the coefficient set.
- Reset mid-EMIT: all state clears immediately. The remaining phases of the interrupted sample are discarded.
- NUM_TAPS = 1: taps_out[0] only; the same rules apply.

Decomposition:
- Shared package interp_filt_pkg holds:
  - a sample typedef (signed logic [DATA_WIDTH-1:0]), with DATA_WIDTH as a package default
  - a phase-counter width function, $clog2(INTERP) with a minimum of 1
- One sub-module, tap_shift_reg: NUM_TAPS-deep signed shift register with async reset, shift-enable and a data input.
- interp_tap_feeder owns the phase FSM, the hold register and the handshake.

Test Plan:
1. Reset with NUM_TAPS = 4, INTERP = 2 -> taps_out {0,0,0,0}, taps_valid 0, in_ready 1. Assert rst asynchronously between clock edges -> outputs clear before the next edge.
2. ZERO_STUFF = 1, out_ready = 1, drive 5 then 7 with in_valid held high:
   - taps sequence {5,0,0,0}, {0,5,0,0}, {7,0,5,0}, {0,7,0,5}
   - in_ready pattern 1,0,1,0
3. ZERO_STUFF = 0, same stimulus -> {5,0,0,0}, {5,5,0,0}, {7,5,5,0}, {7,7,5,5}.
4. Backpressure: out_ready = 0 for 3 cycles while showing {0,5,0,0} -> taps, phase and taps_valid frozen, in_ready 0. Release -> 7 is accepted and the sequence resumes with no loss.
5. Reset mid-EMIT: assert rst while phase = 1 -> taps all 0, taps_valid 0. After release, first accept of 3 -> {3,0,0,0}.
6. INTERP = 1, continuous input -32, 31, -1:
   - in_ready stays 1
   - taps {-32,0,0,0}, {31,-32,0,0}, {-1,31,-32,0}, with values bit-exact

Source files
------------

// File: rtl/interp_filt_pkg.sv
// Shared types and helpers for the interpolation filter datapath.
package interp_filt_pkg;

    localparam int DATA_WIDTH = 6;

    typedef logic signed [DATA_WIDTH-1:0] sample_t;

    // Phase counter width; a factor of 1 still needs a one-bit counter.
    function automatic int phase_w(input int interp);
        return (interp > 1) ? $clog2(interp) : 1;
    endfunction

endpackage

// File: rtl/tap_shift_reg.sv
// Signed delay line: on shift_en, din enters index 0 and every tap moves up one slot.
module tap_shift_reg #(
    parameter int DATA_WIDTH = 6,
    parameter int NUM_TAPS   = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         shift_en,
    input  logic signed [DATA_WIDTH-1:0] din,
    output logic signed [DATA_WIDTH-1:0] taps [NUM_TAPS-1:0]
);

    logic signed [DATA_WIDTH-1:0] taps_q [NUM_TAPS-1:0];
    logic signed [DATA_WIDTH-1:0] taps_d [NUM_TAPS-1:0];

    always_comb begin
        taps_d = taps_q;
        if (shift_en) begin
            taps_d[0] = din;
            for (int i = 1; i < NUM_TAPS; i++) begin
                taps_d[i] = taps_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                taps_q[i] <= '0;
            end
        end else begin
            taps_q <= taps_d;
        end
    end

    assign taps = taps_q;

endmodule

// File: rtl/interp_tap_feeder.sv
// Upsamples accepted samples by INTERP (zero-stuff or hold) into a signed tap delay line
// and presents the tap vector downstream over valid/ready.
module interp_tap_feeder
    import interp_filt_pkg::*;
#(
    parameter int DATA_WIDTH = 6,
    parameter int NUM_TAPS   = 4,
    parameter int INTERP     = 2,
    parameter int ZERO_STUFF = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    output logic                         taps_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] taps_out [NUM_TAPS-1:0]
);

    localparam int PW = phase_w(INTERP);
    localparam logic [PW-1:0] LAST_PHASE = PW'(INTERP - 1);

    logic [PW-1:0]                phase_q, phase_d;
    logic                         taps_valid_q, taps_valid_d;
    logic signed [DATA_WIDTH-1:0] hold_q, hold_d;

    logic                         adv;
    logic                         in_idle;
    logic                         accept;
    logic                         emit;
    logic                         shift_en;
    logic signed [DATA_WIDTH-1:0] shift_din;

    // State register: phase counter (0 = IDLE, otherwise EMIT), output valid, held sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q      <= '0;
            taps_valid_q <= 1'b0;
            hold_q       <= '0;
        end else begin
            phase_q      <= phase_d;
            taps_valid_q <= taps_valid_d;
            hold_q       <= hold_d;
        end
    end

    // Output / handshake decode.
    always_comb begin
        adv       = !taps_valid_q || out_ready;
        in_idle   = (phase_q == '0);
        in_ready  = in_idle && adv;
        accept    = in_valid && in_ready;
        emit      = !in_idle && adv;
        shift_en  = accept || emit;
        shift_din = accept ? in_data : ((ZERO_STUFF != 0) ? '0 : hold_q);
    end

    // Next state. A stalled EMIT phase falls through every branch and holds.
    always_comb begin
        phase_d      = phase_q;
        taps_valid_d = taps_valid_q;
        hold_d       = hold_q;
        if (accept) begin
            hold_d       = in_data;
            taps_valid_d = 1'b1;
            phase_d      = (INTERP > 1) ? PW'(1) : '0;
        end else if (in_idle && adv) begin
            taps_valid_d = 1'b0;
        end else if (emit) begin
            taps_valid_d = 1'b1;
            phase_d      = (phase_q == LAST_PHASE) ? '0 : phase_q + PW'(1);
        end
    end

    assign taps_valid = taps_valid_q;

    tap_shift_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_TAPS   (NUM_TAPS)
    ) u_taps (
        .clk      (clk),
        .rst      (rst),
        .shift_en (shift_en),
        .din      (shift_din),
        .taps     (taps_out)
    );

endmodule

// File: tb/tb_interp_tap_feeder.sv
// Bench for interp_tap_feeder: three configurations share one stimulus stream and are
// checked every cycle against a phase-queue model plus directed literal vectors.
module tb_interp_tap_feeder;

    logic clk;
    logic rst;
    logic in_valid;
    logic signed [5:0] in_data;
    logic out_ready;

    logic ir0, ir1, ir2;
    logic tv0, tv1, tv2;
    logic signed [5:0] taps0 [3:0];
    logic signed [5:0] taps1 [3:0];
    logic signed [5:0] taps2 [3:0];

    int n_tests = 0;
    int n_fail  = 0;

    interp_tap_feeder #(.DATA_WIDTH(6), .NUM_TAPS(4), .INTERP(2), .ZERO_STUFF(1)) u_zs (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0), .in_data(in_data),
        .taps_valid(tv0), .out_ready(out_ready), .taps_out(taps0));

    interp_tap_feeder #(.DATA_WIDTH(6), .NUM_TAPS(4), .INTERP(2), .ZERO_STUFF(0)) u_sh (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
        .taps_valid(tv1), .out_ready(out_ready), .taps_out(taps1));

    interp_tap_feeder #(.DATA_WIDTH(6), .NUM_TAPS(4), .INTERP(1), .ZERO_STUFF(1)) u_i1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir2), .in_data(in_data),
        .taps_valid(tv2), .out_ready(out_ready), .taps_out(taps2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: each accepted sample expands to a stream of L values; pn counts what remains.
    int mt [3][4];
    bit mv [3];
    int pn [3];
    int pv [3];

    function automatic int lfac(input int k);
        return (k == 2) ? 1 : 2;
    endfunction

    task automatic mpush(input int k, input int v);
        for (int i = 3; i > 0; i--) mt[k][i] = mt[k][i-1];
        mt[k][0] = v;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                for (int i = 0; i < 4; i++) mt[k][i] = 0;
                mv[k] = 0;
                pn[k] = 0;
                pv[k] = 0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (!mv[k] || out_ready) begin
                    if (pn[k] > 0) begin
                        mpush(k, (k == 0) ? 0 : pv[k]);
                        pn[k] = pn[k] - 1;
                        mv[k] = 1;
                    end else if (in_valid) begin
                        mpush(k, int'(in_data));
                        pn[k] = lfac(k) - 1;
                        pv[k] = int'(in_data);
                        mv[k] = 1;
                    end else begin
                        mv[k] = 0;
                    end
                end
            end
        end
    end

    function automatic int dtap(input int k, input int i);
        case (k)
            0:       return int'(taps0[i]);
            1:       return int'(taps1[i]);
            default: return int'(taps2[i]);
        endcase
    endfunction

    function automatic int dtv(input int k);
        case (k)
            0:       return int'(tv0);
            1:       return int'(tv1);
            default: return int'(tv2);
        endcase
    endfunction

    function automatic int dir(input int k);
        case (k)
            0:       return int'(ir0);
            1:       return int'(ir1);
            default: return int'(ir2);
        endcase
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_vec(input int k, input string nm, input int a, input int b,
                           input int c, input int d);
        chk({nm, " tap0"}, dtap(k, 0), a);
        chk({nm, " tap1"}, dtap(k, 1), b);
        chk({nm, " tap2"}, dtap(k, 2), c);
        chk({nm, " tap3"}, dtap(k, 3), d);
    endtask

    // Per-cycle comparison against the model on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 3; k++) begin
                int m_ir;
                m_ir = (pn[k] == 0 && (!mv[k] || out_ready)) ? 1 : 0;
                chk($sformatf("model dut%0d taps_valid", k), dtv(k), int'(mv[k]));
                chk($sformatf("model dut%0d in_ready", k), dir(k), m_ir);
                for (int i = 0; i < 4; i++)
                    chk($sformatf("model dut%0d tap%0d", k, i), dtap(k, i), mt[k][i]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int v);
        in_data = 6'(v);
    endtask

    // Asynchronous reset pulse placed between clock edges; outputs must clear at once.
    task automatic async_reset(input string nm);
        #2;
        rst = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk_vec(k, $sformatf("%s dut%0d", nm, k), 0, 0, 0, 0);
            chk($sformatf("%s dut%0d taps_valid", nm, k), dtv(k), 0);
        end
        #3;
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        #12;
        rst = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk_vec(k, $sformatf("reset dut%0d", k), 0, 0, 0, 0);
            chk($sformatf("reset dut%0d taps_valid", k), dtv(k), 0);
            chk($sformatf("reset dut%0d in_ready", k), dir(k), 1);
        end

        // Zero-stuff and hold sequences, in_valid held high.
        in_valid = 1'b1;
        drive(5);
        chk("seq in_ready c0", int'(ir0), 1);
        step();
        chk_vec(0, "zs c1", 5, 0, 0, 0);
        chk_vec(1, "sh c1", 5, 0, 0, 0);
        chk("seq in_ready c1", int'(ir0), 0);
        drive(7);
        step();
        chk_vec(0, "zs c2", 0, 5, 0, 0);
        chk_vec(1, "sh c2", 5, 5, 0, 0);
        chk("seq in_ready c2", int'(ir0), 1);
        step();
        chk_vec(0, "zs c3", 7, 0, 5, 0);
        chk_vec(1, "sh c3", 7, 5, 5, 0);
        chk("seq in_ready c3", int'(ir0), 0);
        in_valid = 1'b0;
        step();
        chk_vec(0, "zs c4", 0, 7, 0, 5);
        chk_vec(1, "sh c4", 7, 7, 5, 5);
        chk("zs c4 taps_valid", int'(tv0), 1);
        step();
        chk("underrun taps_valid", int'(tv0), 0);
        chk_vec(0, "underrun taps", 0, 7, 0, 5);

        // Backpressure while {0,5,0,0} is shown.
        async_reset("rst async");
        in_valid = 1'b1;
        drive(5);
        step();
        drive(7);
        step();
        chk_vec(0, "bp pre", 0, 5, 0, 0);
        out_ready = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("bp c%0d in_ready", c), int'(ir0), 0);
            step();
            chk_vec(0, $sformatf("bp c%0d", c), 0, 5, 0, 0);
            chk($sformatf("bp c%0d taps_valid", c), int'(tv0), 1);
            chk($sformatf("bp c%0d in_ready after", c), int'(ir0), 0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp release in_ready", int'(ir0), 1);
        step();
        chk_vec(0, "bp resume a", 7, 0, 5, 0);
        chk_vec(1, "bp resume sh", 7, 5, 5, 0);
        in_valid = 1'b0;
        step();
        chk_vec(0, "bp resume b", 0, 7, 0, 5);

        // Reset in the middle of an EMIT phase.
        in_valid = 1'b1;
        drive(9);
        step();
        chk_vec(0, "mid pre", 9, 0, 7, 0);
        async_reset("rst mid-emit");
        drive(3);
        step();
        chk_vec(0, "post rst zs", 3, 0, 0, 0);
        chk_vec(1, "post rst sh", 3, 0, 0, 0);
        in_valid = 1'b0;
        step();
        step();

        // INTERP = 1 pure delay line with extreme values.
        async_reset("rst i1");
        in_valid = 1'b1;
        drive(-32);
        step();
        chk_vec(2, "i1 c1", -32, 0, 0, 0);
        chk("i1 c1 in_ready", int'(ir2), 1);
        drive(31);
        step();
        chk_vec(2, "i1 c2", 31, -32, 0, 0);
        chk("i1 c2 in_ready", int'(ir2), 1);
        drive(-1);
        step();
        chk_vec(2, "i1 c3", -1, 31, -32, 0);
        chk("i1 c3 in_ready", int'(ir2), 1);
        in_valid = 1'b0;
        step();
        chk("i1 idle taps_valid", int'(tv2), 0);
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
